// File: rtl/btn_press_encoder.sv
// Button front end for the Genius game: synchronises and debounces three raw
// buttons, then turns each press/release pair into at most one registered event.
module btn_press_encoder #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = 20
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [2:0] btn,
  input  logic       enable,
  output logic       press_valid,
  output logic [1:0] press_code,
  output logic       press_error,
  output logic       busy
);

  typedef enum logic [1:0] {IDLE, DEB_PRESS, WAIT_REL, DEB_REL} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t           state_q, state_d;
  logic [2:0]       sync1_q, sync2_q;
  logic [2:0]       cap_q, cap_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             valid_q, valid_d;
  logic             error_q, error_d;
  logic [1:0]       code_q, code_d;
  logic             fire;
  logic [2:0]       s;

  assign s = sync2_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      sync1_q <= 3'b000;
      sync2_q <= 3'b000;
      state_q <= WAIT_REL;
      cnt_q   <= '0;
      cap_q   <= 3'b000;
      valid_q <= 1'b0;
      error_q <= 1'b0;
      code_q  <= 2'b00;
    end else begin
      sync1_q <= btn;
      sync2_q <= sync1_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cap_q   <= cap_d;
      valid_q <= valid_d;
      error_q <= error_d;
      code_q  <= code_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cap_d   = cap_q;
    fire    = 1'b0;
    case (state_q)
      IDLE: begin
        if (s != 3'b000 && enable) begin
          cap_d   = s;
          cnt_d   = CNT_ONE;
          state_d = DEB_PRESS;
        end
      end
      DEB_PRESS: begin
        // any change of the sampled pattern or loss of enable abandons the press
        if (s != cap_q || !enable) state_d = (s == 3'b000) ? IDLE : WAIT_REL;
        else if (cnt_q < CNT_MAX)  cnt_d = cnt_q + CNT_ONE;
        else begin
          state_d = WAIT_REL;
          fire    = 1'b1;
        end
      end
      WAIT_REL: begin
        if (s == 3'b000) begin
          cnt_d   = CNT_ONE;
          state_d = DEB_REL;
        end
      end
      DEB_REL: begin
        if (s != 3'b000)          state_d = WAIT_REL;
        else if (cnt_q == CNT_MAX) state_d = IDLE;
        else                       cnt_d = cnt_q + CNT_ONE;
      end
      default: state_d = WAIT_REL;
    endcase
  end

  always_comb begin
    valid_d = 1'b0;
    error_d = 1'b0;
    code_d  = 2'b00;
    if (fire) begin
      case (cap_q)
        3'b001:  begin valid_d = 1'b1; code_d = 2'b00; end
        3'b010:  begin valid_d = 1'b1; code_d = 2'b01; end
        3'b100:  begin valid_d = 1'b1; code_d = 2'b10; end
        default: begin error_d = 1'b1; code_d = 2'b11; end
      endcase
    end
    busy = (state_q != IDLE);
  end

  assign press_valid = valid_q;
  assign press_error = error_q;
  assign press_code  = code_q;

endmodule

// File: tb/tb_btn_press_encoder.sv
// Bench for btn_press_encoder: two instances (debounce 4 and 1) driven in parallel,
// each compared every cycle against a run-length reference model of the button rules.
module tb_btn_press_encoder;

  localparam int NI = 2;
  localparam int DC [NI] = '{4, 1};

  logic                 clock = 1'b0;
  logic                 reset = 1'b1;
  logic [2:0]           btn = 3'b000;
  logic                 enable = 1'b1;
  logic [NI-1:0]        pv, pe, by;
  logic [NI-1:0][1:0]   pc;

  int total = 0;
  int bad   = 0;
  int cyc_n = 0;
  int pv_cnt, pe_cnt, last_pv;
  logic [1:0] last_pc, last_ec;

  // reference model: synchroniser delay line plus run lengths
  bit         armed [NI];
  int         zrun  [NI];
  int         prun  [NI];
  logic [2:0] pval  [NI];
  logic [2:0] ms    [NI];
  logic [2:0] ms1   [NI];
  logic       e_v [NI], e_e [NI], e_b [NI];
  logic [1:0] e_c [NI];

  always #5 clock = ~clock;

  btn_press_encoder #(.DEBOUNCE_CYCLES(4), .CNT_W(20)) u0 (
    .clock(clock), .reset(reset), .btn(btn), .enable(enable),
    .press_valid(pv[0]), .press_code(pc[0]), .press_error(pe[0]), .busy(by[0]));

  btn_press_encoder #(.DEBOUNCE_CYCLES(1), .CNT_W(20)) u1 (
    .clock(clock), .reset(reset), .btn(btn), .enable(enable),
    .press_valid(pv[1]), .press_code(pc[1]), .press_error(pe[1]), .busy(by[1]));

  task automatic chk(string tag, logic [7:0] obs, logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc_n);
    end
  endtask

  task automatic model_step(int k, logic [2:0] b, logic e, logic r);
    logic [2:0] s;
    bit ev;
    ev = 1'b0;
    e_v[k] = 1'b0; e_e[k] = 1'b0; e_c[k] = 2'b00;
    if (r) begin
      armed[k] = 1'b0; zrun[k] = 0; prun[k] = 0;
      ms[k] = 3'b000; ms1[k] = 3'b000;
    end else begin
      s = ms[k];
      if (!armed[k]) begin
        // re-armed only after DC+1 consecutive all-released samples
        if (s == 3'b000) begin
          zrun[k]++;
          if (zrun[k] == DC[k] + 1) begin armed[k] = 1'b1; prun[k] = 0; end
        end else zrun[k] = 0;
      end else if (prun[k] == 0) begin
        if (s != 3'b000 && e) begin prun[k] = 1; pval[k] = s; end
      end else if (s == pval[k] && e) begin
        prun[k]++;
        if (prun[k] == DC[k] + 1) begin
          ev = 1'b1; armed[k] = 1'b0; zrun[k] = 0; prun[k] = 0;
        end
      end else begin
        prun[k] = 0;
        if (s != 3'b000) begin armed[k] = 1'b0; zrun[k] = 0; end
      end
      if (ev) begin
        if ($countones(pval[k]) == 1) begin
          e_v[k] = 1'b1;
          e_c[k] = (pval[k] == 3'b001) ? 2'd0 : (pval[k] == 3'b010) ? 2'd1 : 2'd2;
        end else begin
          e_e[k] = 1'b1;
          e_c[k] = 2'd3;
        end
      end
      ms[k]  = ms1[k];
      ms1[k] = b;
    end
    e_b[k] = !(armed[k] && prun[k] == 0);
  endtask

  task automatic cyc(logic [2:0] b, logic e, logic r);
    btn = b; enable = e; reset = r;
    @(posedge clock);
    for (int k = 0; k < NI; k++) model_step(k, b, e, r);
    #1;
    cyc_n++;
    for (int k = 0; k < NI; k++) begin
      chk($sformatf("valid[%0d]", k), 8'(pv[k]), 8'(e_v[k]));
      chk($sformatf("error[%0d]", k), 8'(pe[k]), 8'(e_e[k]));
      chk($sformatf("code[%0d]", k),  8'(pc[k]), 8'(e_c[k]));
      chk($sformatf("busy[%0d]", k),  8'(by[k]), 8'(e_b[k]));
    end
    if (pv[0] === 1'b1) begin pv_cnt++; last_pv = cyc_n; last_pc = pc[0]; end
    if (pe[0] === 1'b1) begin pe_cnt++; last_ec = pc[0]; end
  endtask

  task automatic hold(logic [2:0] b, logic e, int n);
    for (int i = 0; i < n; i++) cyc(b, e, 1'b0);
  endtask

  task automatic clr();
    pv_cnt = 0; pe_cnt = 0; last_pv = -1; last_pc = 2'b00; last_ec = 2'b00;
  endtask

  initial begin
    int e1, hl;
    logic [2:0] rb;
    logic re, rr;
    clr();
    // reset and release
    cyc(3'b000, 1'b1, 1'b1);
    cyc(3'b000, 1'b1, 1'b1);
    chk("rst_busy", 8'(by[0]), 8'd1);
    hold(3'b000, 1'b1, 8);
    chk("idle_after_rst", 8'(by[0]), 8'd0);

    // single clean press of btn[1] and its latency
    clr();
    e1 = cyc_n + 1;
    hold(3'b010, 1'b1, 20);
    chk("t1_count", 8'(pv_cnt), 8'd1);
    chk("t1_code", 8'(last_pc), 8'd1);
    chk("t1_latency", 8'(last_pv - e1), 8'd6);
    hold(3'b000, 1'b1, 6);
    chk("t1_busy_rel_5", 8'(by[0]), 8'd1);
    cyc(3'b000, 1'b1, 1'b0);
    chk("t1_busy_rel_6", 8'(by[0]), 8'd0);

    // bounce, then steady btn[0]
    clr();
    for (int i = 0; i < 12; i++) cyc(((i / 2) % 2 == 0) ? 3'b001 : 3'b000, 1'b1, 1'b0);
    chk("t2_bounce_none", 8'(pv_cnt + pe_cnt), 8'd0);
    hold(3'b001, 1'b1, 12);
    chk("t2_count", 8'(pv_cnt), 8'd1);
    chk("t2_code", 8'(last_pc), 8'd0);
    hold(3'b000, 1'b1, 10);

    // multi-button press
    clr();
    hold(3'b101, 1'b1, 12);
    chk("t3_err_count", 8'(pe_cnt), 8'd1);
    chk("t3_err_code", 8'(last_ec), 8'd3);
    chk("t3_no_valid", 8'(pv_cnt), 8'd0);

    // 100 held with enable low, then enable raised while still held
    clr();
    hold(3'b100, 1'b0, 10);
    hold(3'b100, 1'b1, 10);
    chk("t4_no_event", 8'(pv_cnt + pe_cnt), 8'd0);
    hold(3'b000, 1'b1, 10);
    hold(3'b100, 1'b1, 12);
    chk("t4_count", 8'(pv_cnt), 8'd1);
    chk("t4_code", 8'(last_pc), 8'd2);
    hold(3'b000, 1'b1, 10);

    // button held through reset
    clr();
    cyc(3'b100, 1'b1, 1'b1);
    cyc(3'b100, 1'b1, 1'b1);
    hold(3'b100, 1'b1, 15);
    chk("t5_no_event", 8'(pv_cnt + pe_cnt), 8'd0);
    hold(3'b000, 1'b1, 10);
    hold(3'b100, 1'b1, 12);
    chk("t5_count", 8'(pv_cnt), 8'd1);
    hold(3'b000, 1'b1, 10);

    // reset pulse while debouncing a press
    clr();
    hold(3'b010, 1'b1, 4);
    cyc(3'b010, 1'b1, 1'b1);
    chk("t6_rst_valid", 8'(pv[0]), 8'd0);
    chk("t6_rst_busy", 8'(by[0]), 8'd1);
    hold(3'b010, 1'b1, 12);
    chk("t6_no_event", 8'(pv_cnt + pe_cnt), 8'd0);
    chk("t6_busy_held", 8'(by[0]), 8'd1);
    hold(3'b000, 1'b1, 10);
    chk("t6_busy_released", 8'(by[0]), 8'd0);

    // random traffic against the model
    for (int n = 0; n < 150; n++) begin
      rb = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 2) == 0) rb = 3'b000;
      re = ($urandom_range(0, 4) != 0);
      rr = ($urandom_range(0, 49) == 0);
      hl = $urandom_range(1, 9);
      for (int i = 0; i < hl; i++) cyc(rb, re, (i == 0) ? rr : 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
